id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/venus_pkg.sv | 87 ++++++++
 rtl/regfile.sv | 32 +++
 rtl/id_stage.sv | 108 ++++++++++
 tb/tb_id_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/venus_pkg.sv
// Shared decode definitions for the venus ID stage: field positions, opcode classes,
// the pipeline-register layout and its bubble value.
package venus_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned PcW      = 16;
  localparam int unsigned RegAddrW = 4;
  localparam int unsigned OpcodeW  = 7;
  localparam int unsigned NumRegs  = 16;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 25;
  localparam int unsigned RdMsb     = 24;
  localparam int unsigned RdLsb     = 21;
  localparam int unsigned RsMsb     = 20;
  localparam int unsigned RsLsb     = 17;
  localparam int unsigned ImmfBit   = 16;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [2:0] {
    ClsInte  = 3'b000,
    ClsLogic = 3'b001,
    ClsShift = 3'b010,
    ClsLd    = 3'b011,
    ClsSt    = 3'b100,
    ClsBr    = 3'b101,
    ClsIll6  = 3'b110,
    ClsIll7  = 3'b111
  } op_class_e;

  typedef enum logic {
    StIdle,
    StSquash
  } id_state_e;

  typedef struct packed {
    logic [DataW-1:0]    rd_value;
    logic [DataW-1:0]    rs_value;
    logic [DataW-1:0]    imm_value;
    logic [RegAddrW-1:0] rd_addr;
    logic [PcW-1:0]      pc_value;
    logic [OpcodeW-1:0]  opcode;
    logic                ctrl_inte;
    logic                ctrl_logic;
    logic                ctrl_shift;
    logic                ctrl_ld;
    logic                ctrl_st;
    logic                ctrl_br;
    logic                immf;
    logic                rsv;
  } id_out_t;

  localparam id_out_t Bubble = '0;

  // Illegal classes collapse to Bubble so nothing downstream acts on them.
  function automatic id_out_t decode_inst(input logic [DataW-1:0] inst,
                                          input logic [PcW-1:0]   pc,
                                          input logic [DataW-1:0] rd_val,
                                          input logic [DataW-1:0] rs_val);
    id_out_t   o;
    op_class_e cls;
    logic [15:0] imm16;
    cls   = op_class_e'(inst[OpcodeMsb -: 3]);
    imm16 = inst[ImmMsb:ImmLsb];
    o           = Bubble;
    o.opcode    = inst[OpcodeMsb:OpcodeLsb];
    o.rd_addr   = inst[RdMsb:RdLsb];
    o.pc_value  = pc;
    o.rd_value  = rd_val;
    o.rs_value  = rs_val;
    o.immf      = inst[ImmfBit];
    o.imm_value = (cls == ClsLogic) ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    case (cls)
      ClsInte:  o.ctrl_inte  = 1'b1;
      ClsLogic: o.ctrl_logic = 1'b1;
      ClsShift: o.ctrl_shift = 1'b1;
      ClsLd:    o.ctrl_ld    = 1'b1;
      ClsSt:    o.ctrl_st    = 1'b1;
      ClsBr:    o.ctrl_br    = 1'b1;
      default:  o = Bubble;
    endcase
    o.rsv = o.ctrl_inte | o.ctrl_logic | o.ctrl_shift | o.ctrl_ld;
    return o;
  endfunction

endpackage

// File: rtl/regfile.sv
// 16 x 32 register file: two combinational read ports, one synchronous write port,
// with write-through so a same-cycle read of the written address sees the new data.
module regfile
  import venus_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [DataW-1:0]    wdata_i,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [DataW-1:0]    rdata_a_o,
  output logic [DataW-1:0]    rdata_b_o
);

  logic [DataW-1:0] regs_q [NumRegs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes inst_i, reads operands from the register file and
// registers everything for ex, with stall hold, branch flush and a one-cycle squash.
module id_stage
  import venus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        inst_v_i,
  input  logic [15:0] pc_i,
  input  logic        stall_i,
  input  logic        branch_en_i,
  input  logic        wb_en_i,
  input  logic [3:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic [31:0] rd_value_o,
  output logic [31:0] rs_value_o,
  output logic [31:0] imm_value_o,
  output logic [3:0]  rd_addr_o,
  output logic [15:0] pc_value_o,
  output logic [6:0]  opcode_o,
  output logic        ctrl_inte_o,
  output logic        ctrl_logic_o,
  output logic        ctrl_shift_o,
  output logic        ctrl_ld_o,
  output logic        ctrl_st_o,
  output logic        ctrl_br_o,
  output logic        immf_o,
  output logic        rsv_o
);

  id_state_e           state_q, state_d;
  id_out_t             out_q, out_d;
  logic [RegAddrW-1:0] rs_addr_q, rs_addr_d;
  logic [RegAddrW-1:0] raddr_rd, raddr_rs;
  logic [DataW-1:0]    rdata_rd, rdata_rs;
  logic                hold;
  logic                held_live;

  // While holding, the read ports track the held sources so a write refreshes the operands.
  assign hold      = stall_i && !branch_en_i && (state_q == StIdle);
  assign held_live = out_q.rsv | out_q.ctrl_st | out_q.ctrl_br;
  assign raddr_rd  = hold ? out_q.rd_addr : inst_i[RdMsb:RdLsb];
  assign raddr_rs  = hold ? rs_addr_q : inst_i[RsMsb:RsLsb];

  regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (wb_en_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (raddr_rd),
    .raddr_b_i (raddr_rs),
    .rdata_a_o (rdata_rd),
    .rdata_b_o (rdata_rs)
  );

  always_comb begin
    out_d     = out_q;
    rs_addr_d = rs_addr_q;
    state_d   = ((state_q == StIdle) && branch_en_i) ? StSquash : StIdle;
    if (branch_en_i || (state_q == StSquash)) begin
      out_d     = Bubble;
      rs_addr_d = '0;
    end else if (stall_i) begin
      if (held_live) begin
        out_d.rd_value = rdata_rd;
        out_d.rs_value = rdata_rs;
      end
    end else if (!inst_v_i) begin
      out_d     = Bubble;
      rs_addr_d = '0;
    end else begin
      out_d     = decode_inst(inst_i, pc_i, rdata_rd, rdata_rs);
      rs_addr_d = inst_i[RsMsb:RsLsb];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      out_q     <= Bubble;
      rs_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      rs_addr_q <= rs_addr_d;
    end
  end

  assign stall_o      = stall_i;
  assign rd_value_o   = out_q.rd_value;
  assign rs_value_o   = out_q.rs_value;
  assign imm_value_o  = out_q.imm_value;
  assign rd_addr_o    = out_q.rd_addr;
  assign pc_value_o   = out_q.pc_value;
  assign opcode_o     = out_q.opcode;
  assign ctrl_inte_o  = out_q.ctrl_inte;
  assign ctrl_logic_o = out_q.ctrl_logic;
  assign ctrl_shift_o = out_q.ctrl_shift;
  assign ctrl_ld_o    = out_q.ctrl_ld;
  assign ctrl_st_o    = out_q.ctrl_st;
  assign ctrl_br_o    = out_q.ctrl_br;
  assign immf_o       = out_q.immf;
  assign rsv_o        = out_q.rsv;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a behavioural decode model, plus directed
// literal checks for decode, bypass, stall, flush, illegal opcodes and reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_v_i;
  logic [15:0] pc_i;
  logic        stall_i;
  logic        branch_en_i;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [3:0]  rd_addr_o;
  logic [15:0] pc_value_o;
  logic [6:0]  opcode_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
  logic        immf_o, rsv_o;

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_v_i     (inst_v_i),
    .pc_i         (pc_i),
    .stall_i      (stall_i),
    .branch_en_i  (branch_en_i),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .stall_o      (stall_o),
    .rd_value_o   (rd_value_o),
    .rs_value_o   (rs_value_o),
    .imm_value_o  (imm_value_o),
    .rd_addr_o    (rd_addr_o),
    .pc_value_o   (pc_value_o),
    .opcode_o     (opcode_o),
    .ctrl_inte_o  (ctrl_inte_o),
    .ctrl_logic_o (ctrl_logic_o),
    .ctrl_shift_o (ctrl_shift_o),
    .ctrl_ld_o    (ctrl_ld_o),
    .ctrl_st_o    (ctrl_st_o),
    .ctrl_br_o    (ctrl_br_o),
    .immf_o       (immf_o),
    .rsv_o        (rsv_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_regs [16];
  logic [31:0] e_rd_value, e_rs_value, e_imm;
  logic [3:0]  e_rd_addr, e_rs_addr;
  logic [15:0] e_pc;
  logic [6:0]  e_op;
  logic [5:0]  e_ctrl;  // {inte, logic, shift, ld, st, br}
  logic        e_immf, e_rsvb;
  logic        m_squash;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rf(input logic [3:0] a);
    return (wb_en_i && (wb_addr_i == a)) ? wb_data_i : m_regs[a];
  endfunction

  task automatic set_bubble();
    e_rd_value = '0; e_rs_value = '0; e_imm = '0; e_rd_addr = '0; e_rs_addr = '0;
    e_pc = '0; e_op = '0; e_ctrl = '0; e_immf = 1'b0; e_rsvb = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    set_bubble();
    m_squash = 1'b0;
  endtask

  task automatic model_update();
    logic [2:0]  cls;
    logic [15:0] imm16;
    cls   = inst_i[31:29];
    imm16 = inst_i[15:0];
    if (branch_en_i || m_squash) begin
      set_bubble();
    end else if (stall_i) begin
      if (e_ctrl != 6'd0) begin
        e_rd_value = rf(e_rd_addr);
        e_rs_value = rf(e_rs_addr);
      end
    end else if (!inst_v_i || cls >= 3'd6) begin
      set_bubble();
    end else begin
      e_op       = inst_i[31:25];
      e_rd_addr  = inst_i[24:21];
      e_rs_addr  = inst_i[20:17];
      e_immf     = inst_i[16];
      e_imm      = (cls == 3'd1) ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
      e_pc       = pc_i;
      e_rd_value = rf(e_rd_addr);
      e_rs_value = rf(e_rs_addr);
      e_ctrl     = 6'b100000 >> cls;
      e_rsvb     = (cls <= 3'd3);
    end
    m_squash = branch_en_i && !m_squash;
    if (wb_en_i) m_regs[wb_addr_i] = wb_data_i;
  endtask

  task automatic compare_all();
    chk("rd_value", rd_value_o, e_rd_value);
    chk("rs_value", rs_value_o, e_rs_value);
    chk("imm_value", imm_value_o, e_imm);
    chk("rd_addr", 32'(rd_addr_o), 32'(e_rd_addr));
    chk("pc_value", 32'(pc_value_o), 32'(e_pc));
    chk("opcode", 32'(opcode_o), 32'(e_op));
    chk("ctrl", 32'({ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o}),
        32'(e_ctrl));
    chk("immf", 32'(immf_o), 32'(e_immf));
    chk("rsv", 32'(rsv_o), 32'(e_rsvb));
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step();
    #1;
    chk("stall_o", 32'(stall_o), 32'(stall_i));
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_random();
    inst_v_i    = ($urandom_range(3) != 0);
    inst_i      = $urandom;
    pc_i        = 16'($urandom);
    stall_i     = ($urandom_range(3) == 0);
    branch_en_i = ($urandom_range(9) == 0);
    wb_en_i     = 1'($urandom_range(1));
    wb_addr_i   = 4'($urandom);
    wb_data_i   = $urandom;
  endtask

  task automatic drive_idle();
    inst_v_i = 1'b0; inst_i = '0; pc_i = '0; stall_i = 1'b0; branch_en_i = 1'b0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs, input logic immf,
                                          input logic [15:0] imm);
    return {op, rd, rs, immf, imm};
  endfunction

  task automatic reset_mid_traffic();
    rst = 1'b0;
    #1;
    chk("rst_rd_value", rd_value_o, 32'h0);
    chk("rst_rs_value", rs_value_o, 32'h0);
    chk("rst_imm", imm_value_o, 32'h0);
    chk("rst_misc", 32'({rd_addr_o, pc_value_o, opcode_o}), 32'h0);
    chk("rst_ctrl", 32'({ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o,
                        ctrl_br_o, immf_o, rsv_o}), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < 1200; c++) begin
      drive_random();
      step();
    end

    drive_random();
    reset_mid_traffic();
    drive_idle();

    // Decode: integer class, sign-extended; regfile reads 0 after reset.
    inst_v_i = 1'b1; pc_i = 16'h0100;
    inst_i = mk_inst(7'h00, 4'd3, 4'd5, 1'b1, 16'hFFFE);
    step();
    chk("dec_inte", 32'(ctrl_inte_o), 32'd1);
    chk("dec_rsv", 32'(rsv_o), 32'd1);
    chk("dec_imm_sext", imm_value_o, 32'hFFFF_FFFE);
    chk("dec_rs_zero", rs_value_o, 32'h0);

    // Logic class zero-extends.
    inst_i = mk_inst(7'h10, 4'd3, 4'd5, 1'b1, 16'hFFFE);
    step();
    chk("dec_logic", 32'(ctrl_logic_o), 32'd1);
    chk("dec_imm_zext", imm_value_o, 32'h0000_FFFE);

    // Same-cycle write-through.
    wb_en_i = 1'b1; wb_addr_i = 4'd5; wb_data_i = 32'h1234_5678;
    inst_i = mk_inst(7'h20, 4'd3, 4'd5, 1'b0, 16'h0001);
    step();
    chk("bypass_rs", rs_value_o, 32'h1234_5678);
    chk("bypass_shift", 32'(ctrl_shift_o), 32'd1);

    // Three stalled cycles with changing instructions: outputs frozen.
    wb_en_i = 1'b0; stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst_i = mk_inst(7'h30, 4'(k), 4'(k + 7), 1'b1, 16'(k));
      step();
      chk("stall_o_hi", 32'(stall_o), 32'd1);
      chk("stall_opcode", 32'(opcode_o), 32'h20);
      chk("stall_rs", rs_value_o, 32'h1234_5678);
    end
    // A write to the held source register refreshes the held operand.
    wb_en_i = 1'b1; wb_addr_i = 4'd5; wb_data_i = 32'hCAFE_F00D;
    step();
    chk("stall_refresh", rs_value_o, 32'hCAFE_F00D);
    wb_en_i = 1'b0; stall_i = 1'b0;
    inst_i = mk_inst(7'h30, 4'd1, 4'd2, 1'b0, 16'h0004);
    step();
    chk("unstall_ld", 32'(ctrl_ld_o), 32'd1);

    // Flush beats stall, squash bubbles the next one, third decodes.
    branch_en_i = 1'b1; stall_i = 1'b1;
    inst_i = mk_inst(7'h00, 4'd1, 4'd2, 1'b0, 16'h0001);
    step();
    chk("flush_rsv", 32'(rsv_o), 32'd0);
    chk("flush_ctrl", 32'({ctrl_inte_o, ctrl_ld_o}), 32'd0);
    branch_en_i = 1'b0; stall_i = 1'b0;
    step();
    chk("squash_rsv", 32'(rsv_o), 32'd0);
    chk("squash_inte", 32'(ctrl_inte_o), 32'd0);
    step();
    chk("post_squash_inte", 32'(ctrl_inte_o), 32'd1);
    chk("post_squash_rsv", 32'(rsv_o), 32'd1);

    // Illegal opcode becomes a bubble.
    inst_i = mk_inst(7'h60, 4'd4, 4'd4, 1'b1, 16'h1234);
    step();
    chk("illegal_rsv", 32'(rsv_o), 32'd0);
    chk("illegal_opcode", 32'(opcode_o), 32'd0);

    for (int c = 0; c < 1200; c++) begin
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
